// File: rtl/adc_max10_seq_ctrl_if.sv
// Register port and MAX10 modular ADC Avalon-ST command/response signals for adc_max10_seq_ctrl.
// The sequencer uses the slave modport; the bus wrapper / ADC core side uses master.
interface adc_max10_seq_ctrl_if #(
  parameter int ADC_ADDR_WIDTH = 4
);
  logic [ADC_ADDR_WIDTH-1:0] read_addr;
  logic [31:0]               read_data;
  logic [ADC_ADDR_WIDTH-1:0] write_addr;
  logic [31:0]               write_data;
  logic                      write_enable;
  logic                      ADC_C_Valid;
  logic [4:0]                ADC_C_Channel;
  logic                      ADC_C_SOP;
  logic                      ADC_C_EOP;
  logic                      ADC_C_Ready;
  logic                      ADC_R_Valid;
  logic [4:0]                ADC_R_Channel;
  logic [11:0]               ADC_R_Data;
  logic                      ADC_R_SOP;
  logic                      ADC_R_EOP;
  logic                      ADC_Trigger;
  logic                      ADC_Interrupt;

  modport slave (
    input  read_addr, write_addr, write_data, write_enable,
    output read_data,
    output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    input  ADC_C_Ready,
    input  ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP,
    input  ADC_Trigger,
    output ADC_Interrupt
  );

  modport master (
    output read_addr, write_addr, write_data, write_enable,
    input  read_data,
    input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    output ADC_C_Ready,
    output ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP,
    output ADC_Trigger,
    input  ADC_Interrupt
  );
endinterface

// File: rtl/adc_max10_seq_ctrl.sv
// Register-mapped channel sequencer for the MAX10 modular ADC core (one command outstanding).
// Define ADC_MAX10_TRIGGER_EN to build the external trigger synchronizer and CTRL.TE.
module adc_max10_seq_ctrl #(
  parameter int ADC_ADDR_WIDTH = 4
) (
  input logic                 CLK,
  input logic                 RESET,
  adc_max10_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP, S_DONE} state_t;

  localparam logic [ADC_ADDR_WIDTH-1:0] A_CTRL = ADC_ADDR_WIDTH'(0);
  localparam logic [ADC_ADDR_WIDTH-1:0] A_MASK = ADC_ADDR_WIDTH'(1);
  localparam logic [ADC_ADDR_WIDTH-1:0] A_STAT = ADC_ADDR_WIDTH'(2);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_work, w_work_nxt;
  logic [2:0]  r_chan, w_chan_nxt;
  logic        r_first, w_first_nxt;
  logic        w_set_if;
  logic        r_en, r_fr, r_ie, r_if, r_irq;
  logic [7:0]  r_mask;
  logic [11:0] r_data [8];
  logic [31:0] r_rdata, w_rdata;
  logic [7:0]  w_rest;
  logic        w_busy, w_ctrl_wr, w_sc_start, w_trig_start, w_start, w_te, w_resp_store;

  function automatic logic [2:0] f_lowest(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  assign w_busy       = (r_state != S_IDLE);
  assign w_ctrl_wr    = bus.write_enable && (bus.write_addr == A_CTRL);
  assign w_sc_start   = w_ctrl_wr && bus.write_data[1] && bus.write_data[0];
  assign w_start      = w_sc_start || w_trig_start;
  assign w_rest       = r_work & ~(8'd1 << r_chan);
  assign w_resp_store = (r_state == S_RESP) && bus.ADC_R_Valid && (bus.ADC_R_Channel < 5'd8);

`ifdef ADC_MAX10_TRIGGER_EN
  logic r_te, r_trig_s1, r_trig_s2, r_trig_s3;
  logic w_unused;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_te      <= 1'b0;
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_trig_s3 <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_te <= bus.write_data[2];
      r_trig_s1 <= bus.ADC_Trigger;
      r_trig_s2 <= r_trig_s1;
      r_trig_s3 <= r_trig_s2;
    end
  end

  assign w_te         = r_te;
  assign w_trig_start = r_trig_s2 && !r_trig_s3 && r_en && r_te;
  assign w_unused     = ^{bus.write_data[31:8], bus.ADC_R_SOP, bus.ADC_R_EOP};
`else
  logic w_unused;
  assign w_te         = 1'b0;
  assign w_trig_start = 1'b0;
  assign w_unused     = ^{bus.write_data[31:8], bus.ADC_R_SOP, bus.ADC_R_EOP, bus.ADC_Trigger};
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_chan  <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_chan  <= w_chan_nxt;
      r_first <= w_first_nxt;
    end
  end

  // Starts only in IDLE with a non-empty mask; EN cleared mid-sequence exits after the response without IF.
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_chan_nxt  = r_chan;
    w_first_nxt = r_first;
    w_set_if    = 1'b0;
    case (r_state)
      S_IDLE: if (w_start && (r_mask != 8'd0)) begin
        w_work_nxt  = r_mask;
        w_chan_nxt  = f_lowest(r_mask);
        w_first_nxt = 1'b1;
        w_state_nxt = S_CMD;
      end
      S_CMD: if (bus.ADC_C_Ready) w_state_nxt = S_RESP;
      S_RESP: if (bus.ADC_R_Valid) begin
        w_work_nxt  = w_rest;
        w_first_nxt = 1'b0;
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_rest != 8'd0) begin
          w_chan_nxt  = f_lowest(w_rest);
          w_state_nxt = S_CMD;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_set_if = 1'b1;
        if (r_fr && r_en && (r_mask != 8'd0)) begin
          w_work_nxt  = r_mask;
          w_chan_nxt  = f_lowest(r_mask);
          w_first_nxt = 1'b1;
          w_state_nxt = S_CMD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_en   <= 1'b0;
      r_fr   <= 1'b0;
      r_ie   <= 1'b0;
      r_mask <= '0;
      r_if   <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_en <= bus.write_data[0];
        r_fr <= bus.write_data[3];
        r_ie <= bus.write_data[4];
      end
      if (bus.write_enable && (bus.write_addr == A_MASK)) r_mask <= bus.write_data[7:0];
      if (w_set_if) r_if <= 1'b1;
      else if (bus.write_enable && (bus.write_addr == A_STAT) && bus.write_data[1]) r_if <= 1'b0;
      r_irq <= r_if & r_ie;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) r_data[i] <= '0;
    end else if (w_resp_store) begin
      r_data[bus.ADC_R_Channel[2:0]] <= bus.ADC_R_Data;
    end
  end

  // Word addresses 8..15 map onto DATA0..DATA7.
  always_comb begin
    w_rdata = '0;
    case (bus.read_addr)
      A_CTRL:  w_rdata[4:0] = {r_ie, r_fr, w_te, 1'b0, r_en};
      A_MASK:  w_rdata[7:0] = r_mask;
      A_STAT:  w_rdata[1:0] = {r_if, w_busy};
      default: w_rdata = '0;
    endcase
    if ((bus.read_addr >> 3) == ADC_ADDR_WIDTH'(1)) w_rdata[11:0] = r_data[bus.read_addr[2:0]];
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_rdata <= '0;
    else       r_rdata <= w_rdata;
  end

  assign bus.read_data     = r_rdata;
  assign bus.ADC_C_Valid   = (r_state == S_CMD);
  assign bus.ADC_C_Channel = (r_state == S_CMD) ? {2'b00, r_chan} : 5'd0;
  assign bus.ADC_C_SOP     = (r_state == S_CMD) && r_first;
  assign bus.ADC_C_EOP     = (r_state == S_CMD) && (w_rest == 8'd0);
  assign bus.ADC_Interrupt = r_irq;

endmodule

// File: tb/tb_adc_max10_seq_ctrl.sv
// Self-checking bench for adc_max10_seq_ctrl: register vectors, directed corner sequences,
// and randomized sequences against a mask-to-command-list reference model.
`timescale 1ns/1ps
module tb_adc_max10_seq_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  adc_max10_seq_ctrl_if #(.ADC_ADDR_WIDTH(4)) bus ();
  adc_max10_seq_ctrl #(.ADC_ADDR_WIDTH(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));

  typedef struct {
    string       name;
    logic [3:0]  wAddr;
    logic [31:0] wData;
    logic [3:0]  rAddr;
    logic [31:0] expData;
  } regVec_t;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] adcVal [8];
  logic [11:0] dataModel [8];
  int          readyMode;
  bit          autoResp;
  bit          respPending;
  int          respWait;
  logic [4:0]  respCh;
  int          cmdCh [$];
  bit          cmdSop [$];
  bit          cmdEop [$];
  int          expCh [$];
  bit          expSop [$];
  bit          expEop [$];
  regVec_t     vecs [8];

`ifdef ADC_MAX10_TRIGGER_EN
  localparam logic [31:0] CTRL_ALL = 32'h1D;
`else
  localparam logic [31:0] CTRL_ALL = 32'h19;
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of the ADC core model: logs accepted commands, answers after a short random latency.
  task automatic tick();
    bit acc, sop, eop;
    int ch;
    acc = (bus.ADC_C_Valid === 1'b1) && (bus.ADC_C_Ready === 1'b1);
    ch  = int'(bus.ADC_C_Channel);
    sop = bus.ADC_C_SOP;
    eop = bus.ADC_C_EOP;
    @(posedge CLK);
    #1;
    bus.ADC_R_Valid = 1'b0;
    if (acc) begin
      cmdCh.push_back(ch);
      cmdSop.push_back(sop);
      cmdEop.push_back(eop);
      if (autoResp) begin
        respPending = 1'b1;
        respCh      = 5'(ch);
        respWait    = $urandom_range(0, 3);
      end
    end
    if (respPending) begin
      if (respWait == 0) begin
        respPending       = 1'b0;
        bus.ADC_R_Valid   = 1'b1;
        bus.ADC_R_Channel = respCh;
        bus.ADC_R_Data    = adcVal[respCh[2:0]];
      end else begin
        respWait--;
      end
    end
    case (readyMode)
      0:       bus.ADC_C_Ready = 1'b1;
      1:       bus.ADC_C_Ready = 1'($urandom_range(0, 1));
      default: bus.ADC_C_Ready = 1'b0;
    endcase
  endtask

  task automatic writeReg(input logic [3:0] addr, input logic [31:0] data);
    bus.write_addr   = addr;
    bus.write_data   = data;
    bus.write_enable = 1'b1;
    tick();
    bus.write_enable = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
    bus.read_addr = addr;
    tick();
    data = bus.read_data;
  endtask

  task automatic waitIdle(input string name, input int budget);
    logic [31:0] s;
    int n;
    n = 0;
    readReg(4'd2, s);
    while (s[0] && n < budget) begin
      readReg(4'd2, s);
      n++;
    end
    checkOutput({name, "_idle"}, {31'b0, s[0]}, 32'h0);
  endtask

  // Reference: one command per set mask bit in ascending order, SOP first, EOP last.
  task automatic buildExpected(input logic [7:0] m);
    int total, k;
    expCh.delete();
    expSop.delete();
    expEop.delete();
    total = $countones(m);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        expCh.push_back(i);
        expSop.push_back(k == 0);
        expEop.push_back(k == total - 1);
        dataModel[i] = adcVal[i];
        k++;
      end
    end
  endtask

  task automatic checkCmds(input string name);
    int n;
    checkOutput({name, "_count"}, cmdCh.size(), expCh.size());
    n = (cmdCh.size() < expCh.size()) ? cmdCh.size() : expCh.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_ch%0d", name, i), cmdCh[i], expCh[i]);
      checkOutput($sformatf("%s_sop%0d", name, i), 32'(cmdSop[i]), 32'(expSop[i]));
      checkOutput($sformatf("%s_eop%0d", name, i), 32'(cmdEop[i]), 32'(expEop[i]));
    end
    cmdCh.delete();
    cmdSop.delete();
    cmdEop.delete();
  endtask

  task automatic applyStimulus(input regVec_t v);
    logic [31:0] rd;
    writeReg(v.wAddr, v.wData);
    readReg(v.rAddr, rd);
    checkOutput(v.name, rd, v.expData);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  m;
    int          n;

    vecs[0] = '{"ctrl_all_bits", 4'd0, 32'hFFFF_FFFF, 4'd0, CTRL_ALL};
    vecs[1] = '{"status_mask0_start", 4'd3, 32'hFFFF_FFFF, 4'd2, 32'h0};
    vecs[2] = '{"mask_rw", 4'd1, 32'h0000_01A5, 4'd1, 32'hA5};
    vecs[3] = '{"data_wr_ignored", 4'd11, 32'h0000_0FFF, 4'd11, 32'h0};
    vecs[4] = '{"addr5_reads0", 4'd5, 32'h1234_5678, 4'd5, 32'h0};
    vecs[5] = '{"status_w1c_idle", 4'd2, 32'h0000_0003, 4'd2, 32'h0};
    vecs[6] = '{"ctrl_clear", 4'd0, 32'h0, 4'd0, 32'h0};
    vecs[7] = '{"mask_clear", 4'd1, 32'h0, 4'd1, 32'h0};

    RESET = 1'b1;
    bus.read_addr = '0; bus.write_addr = '0; bus.write_data = '0; bus.write_enable = 1'b0;
    bus.ADC_C_Ready = 1'b0; bus.ADC_R_Valid = 1'b0; bus.ADC_R_Channel = '0; bus.ADC_R_Data = '0;
    bus.ADC_R_SOP = 1'b0; bus.ADC_R_EOP = 1'b0; bus.ADC_Trigger = 1'b0;
    readyMode = 0; autoResp = 1'b1; respPending = 1'b0; respWait = 0; respCh = '0;
    for (int i = 0; i < 8; i++) begin
      adcVal[i] = 12'($urandom);
      dataModel[i] = '0;
    end
    repeat (3) tick();
    RESET = 1'b0;

    checkOutput("reset_c_valid", 32'(bus.ADC_C_Valid), 32'h0);
    checkOutput("reset_irq", 32'(bus.ADC_Interrupt), 32'h0);
    for (int a = 0; a < 16; a++) begin
      readReg(4'(a), rd);
      checkOutput($sformatf("reset_reg%0d", a), rd, 32'h0);
    end

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Same-cycle write and read of MASK returns the old contents.
    writeReg(4'd1, 32'h33);
    bus.read_addr = 4'd1;
    bus.write_addr = 4'd1; bus.write_data = 32'h0F; bus.write_enable = 1'b1;
    tick();
    bus.write_enable = 1'b0;
    checkOutput("rw_same_cycle_old", bus.read_data, 32'h33);
    readReg(4'd1, rd);
    checkOutput("rw_same_cycle_new", rd, 32'h0F);

    adcVal[0] = 12'h123; adcVal[2] = 12'hABC;
    writeReg(4'd1, 32'h05);
    writeReg(4'd0, 32'h11);
    cmdCh.delete(); cmdSop.delete(); cmdEop.delete();
    writeReg(4'd0, 32'h13);
    buildExpected(8'h05);
    waitIdle("seq05", 200);
    checkCmds("seq05");
    readReg(4'd8, rd);  checkOutput("seq05_data0", rd, 32'h123);
    readReg(4'd10, rd); checkOutput("seq05_data2", rd, 32'hABC);
    readReg(4'd0, rd);  checkOutput("seq05_ctrl_sc_reads0", rd, 32'h11);
    readReg(4'd2, rd);  checkOutput("seq05_status", rd, 32'h2);
    checkOutput("seq05_irq", 32'(bus.ADC_Interrupt), 32'h1);
    writeReg(4'd2, 32'h2);
    tick();
    checkOutput("seq05_irq_cleared", 32'(bus.ADC_Interrupt), 32'h0);
    readReg(4'd2, rd);  checkOutput("seq05_if_cleared", rd, 32'h0);

    readyMode = 2; bus.ADC_C_Ready = 1'b0;
    writeReg(4'd1, 32'h10);
    buildExpected(8'h10);
    writeReg(4'd0, 32'h13);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_valid%0d", i), 32'(bus.ADC_C_Valid), 32'h1);
      checkOutput($sformatf("stall_chan%0d", i), 32'(bus.ADC_C_Channel), 32'h4);
      tick();
    end
    checkOutput("stall_no_accept", cmdCh.size(), 0);
    readyMode = 0; bus.ADC_C_Ready = 1'b1;
    waitIdle("stall", 200);
    checkCmds("stall");
    readReg(4'd12, rd); checkOutput("stall_data4", rd, 32'(dataModel[4]));

    writeReg(4'd1, 32'h01);
    writeReg(4'd0, 32'h19);
    writeReg(4'd0, 32'h1B);
    n = 0;
    while (cmdCh.size() < 3 && n < 300) begin
      tick();
      n++;
    end
    checkOutput("fr_backtoback", 32'(cmdCh.size() >= 3), 32'h1);
    writeReg(4'd0, 32'h18);
    waitIdle("fr_stop", 200);
    for (int i = 0; i < cmdCh.size(); i++) checkOutput($sformatf("fr_ch%0d", i), cmdCh[i], 0);
    n = cmdCh.size();
    repeat (20) tick();
    checkOutput("fr_no_more_cmds", cmdCh.size(), n);
    readReg(4'd2, rd); checkOutput("fr_busy0", 32'(rd[0]), 32'h0);
    dataModel[0] = adcVal[0];
    readReg(4'd8, rd); checkOutput("fr_data0", rd, 32'(adcVal[0]));
    cmdCh.delete(); cmdSop.delete(); cmdEop.delete();

`ifdef ADC_MAX10_TRIGGER_EN
    readyMode = 2; bus.ADC_C_Ready = 1'b0;
    writeReg(4'd2, 32'h2);
    writeReg(4'd1, 32'h02);
    writeReg(4'd0, 32'h15);
    buildExpected(8'h02);
    bus.ADC_Trigger = 1'b1;
    n = 0;
    while (!bus.ADC_C_Valid && n < 10) begin
      tick();
      n++;
    end
    checkOutput("trig_start", 32'(bus.ADC_C_Valid), 32'h1);
    checkOutput("trig_latency_le4", 32'(n <= 4), 32'h1);
    bus.ADC_Trigger = 1'b0;
    repeat (3) tick();
    bus.ADC_Trigger = 1'b1;
    repeat (4) tick();
    readyMode = 0; bus.ADC_C_Ready = 1'b1;
    waitIdle("trig", 200);
    bus.ADC_Trigger = 1'b0;
    repeat (10) tick();
    checkCmds("trig");
    readReg(4'd0, rd); checkOutput("trig_ctrl_te", rd, 32'h15);
`else
    writeReg(4'd1, 32'h02);
    writeReg(4'd0, 32'h15);
    readReg(4'd0, rd); checkOutput("notrig_te_reads0", rd, 32'h11);
    bus.ADC_Trigger = 1'b1;
    repeat (8) tick();
    checkOutput("notrig_no_cmd", cmdCh.size(), 0);
    readReg(4'd2, rd); checkOutput("notrig_busy0", 32'(rd[0]), 32'h0);
    bus.ADC_Trigger = 1'b0;
`endif

    readyMode = 1; autoResp = 1'b1;
    for (int it = 0; it < 25; it++) begin
      m = 8'($urandom);
      if (it % 6 == 0) m = 8'h00;
      for (int i = 0; i < 8; i++) adcVal[i] = 12'($urandom);
      writeReg(4'd0, 32'h11);
      writeReg(4'd2, 32'h2);
      writeReg(4'd1, 32'(m));
      buildExpected(m);
      cmdCh.delete(); cmdSop.delete(); cmdEop.delete();
      writeReg(4'd0, 32'h13);
      if ($urandom_range(0, 1) == 1) writeReg(4'd1, $urandom);
      waitIdle($sformatf("rnd%0d", it), 400);
      checkCmds($sformatf("rnd%0d", it));
      for (int i = 0; i < 8; i++) begin
        readReg(4'(8 + i), rd);
        checkOutput($sformatf("rnd%0d_data%0d", it, i), rd, 32'(dataModel[i]));
      end
      readReg(4'd2, rd);
      checkOutput($sformatf("rnd%0d_status", it), rd, (m != 8'h00) ? 32'h2 : 32'h0);
      checkOutput($sformatf("rnd%0d_irq", it), 32'(bus.ADC_Interrupt), 32'(m != 8'h00));
    end

    readyMode = 0; autoResp = 1'b0; bus.ADC_C_Ready = 1'b1;
    writeReg(4'd1, 32'h08);
    writeReg(4'd0, 32'h11);
    cmdCh.delete(); cmdSop.delete(); cmdEop.delete();
    writeReg(4'd0, 32'h13);
    n = 0;
    while (cmdCh.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rst_cmd_accepted", cmdCh.size(), 1);
    RESET = 1'b1;
    tick();
    checkOutput("rst_c_valid", 32'(bus.ADC_C_Valid), 32'h0);
    RESET = 1'b0;
    readReg(4'd2, rd); checkOutput("rst_busy0", rd, 32'h0);
    bus.ADC_R_Valid = 1'b1; bus.ADC_R_Channel = 5'd3; bus.ADC_R_Data = 12'h5A5;
    tick();
    readReg(4'd11, rd); checkOutput("rst_late_resp_ignored", rd, 32'h0);
    readReg(4'd0, rd);  checkOutput("rst_ctrl0", rd, 32'h0);
    checkOutput("rst_c_valid_after", 32'(bus.ADC_C_Valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_max10_seq_ctrl.md
Name: adc_max10_seq_ctrl

Overview:
- Register-mapped sequencer controlling the MAX10 modular ADC core through its Avalon-ST command and response interfaces.
- A bus-side wrapper (AHB-Lite) drives the simple read/write register port. The block iterates over a channel mask, issues one command per enabled channel, and stores each 12-bit result.
- Raises an interrupt when a sequence completes. Conversions start by software, by an external trigger, or automatically in free-running mode.

Parameters:
- ADC_ADDR_WIDTH, 4, word-address width of the register port.

Ports:
- CLK  in  1  system clock; the ADC core command/response side uses the same clock.
- RESET  in  1  synchronous, active-high reset.
- read_addr  in  ADC_ADDR_WIDTH  register read word address.
- read_data  out  32  read data, one-cycle latency.
- write_addr  in  ADC_ADDR_WIDTH  register write word address.
- write_data  in  32  write data.
- write_enable  in  1  write strobe, one cycle per write.
- ADC_C_Valid  out  1  command valid.
- ADC_C_Channel  out  5  command channel number.
- ADC_C_SOP  out  1  command start of packet.
- ADC_C_EOP  out  1  command end of packet.
- ADC_C_Ready  in  1  command accepted by the ADC core.
- ADC_R_Valid  in  1  response valid, single-cycle pulse.
- ADC_R_Channel  in  5  response channel.
- ADC_R_Data  in  12  conversion result.
- ADC_R_SOP  in  1  response start of packet (unused).
- ADC_R_EOP  in  1  response end of packet (unused).
- ADC_Trigger  in  1  external asynchronous start trigger.
- ADC_Interrupt  out  1  level interrupt request.

Behaviour:
- Register map (word addresses):
  - 0 CTRL: bit0 EN, bit1 SC, bit2 TE, bit3 FR, bit4 IE.
  - 1 MASK: bits[7:0], bit i enables channel i.
  - 2 STATUS: bit0 BUSY (read-only), bit1 IF (write-1-to-clear).
  - 3..7: read 0.
  - 8..15 DATA0..DATA7: bits[11:0] hold the last result for channel 0..7; upper bits read 0; writes ignored.
- Unused bits read 0.
- Reset values: all registers 0; ADC_C_Valid/SOP/EOP 0; ADC_C_Channel 0; ADC_Interrupt 0; read_data 0.
- read_data is registered: the value at read_addr is returned on the next CLK edge. A same-cycle write to the same address returns the old value.
- SC is self-clearing and always reads 0. SC=1 with EN=1 while idle starts a sequence; SC is ignored while BUSY or while EN=0.
- Trigger path: ADC_Trigger passes through a 2-flop synchronizer, then a rising-edge detector. An edge starts a sequence when EN=1, TE=1 and idle; otherwise it is dropped, not queued.
- Starting with MASK=0 does nothing: no command is issued and IF is not set.
- FSM:
  - IDLE: on start, latch MASK into a working copy, select the lowest set bit, go to CMD.
  - CMD: ADC_C_Valid=1; ADC_C_Channel = selected index; ADC_C_SOP=1 on the first channel of the sequence; ADC_C_EOP=1 on the last. Hold all command outputs stable until ADC_C_Valid && ADC_C_Ready, then go to RESP.
  - RESP: on ADC_R_Valid, if ADC_R_Channel<8 write ADC_R_Data into DATA[ADC_R_Channel]; results with other channel numbers are discarded. Then clear that bit in the working copy. If bits remain, go to CMD with the next higher set bit. Otherwise go to DONE.
  - DONE: set IF for one cycle of action. If FR=1 and EN=1, restart immediately from a fresh MASK snapshot; else return to IDLE.
- Only one command is ever outstanding.
- BUSY=1 in every state except IDLE.
- MASK writes during a sequence take effect at the next sequence.
- Clearing EN mid-sequence: the current command/response completes, then the FSM returns to IDLE without setting IF.
- ADC_Interrupt is registered: it equals IF & IE on the next cycle.
- IF set and a software clear in the same cycle: set wins.
- Reset mid-operation: FSM returns to IDLE at once, ADC_C_Valid drops, and any late response is ignored.

Optional Feature:
- Macro ADC_MAX10_TRIGGER_EN.
- Defined: the synchronizer, edge detector and CTRL.TE exist as described.
- Undefined: ADC_Trigger is ignored, TE is not implemented and reads 0, and no trigger logic is synthesized.

Test Plan:
- Reset then read every register -> all read 0; ADC_C_Valid=0; ADC_Interrupt=0.
- MASK=0x05, CTRL=0x11 (EN|IE), then SC; ADC core model returns 0x123 for ch0 and 0xABC for ch2 -> commands ch0 (SOP=1, EOP=0) then ch2 (SOP=0, EOP=1); DATA0=0x123; DATA2=0xABC; STATUS=0x2; ADC_Interrupt=1. Write STATUS=0x2 -> IF=0 and ADC_Interrupt=0.
- Hold ADC_C_Ready=0 for 5 cycles -> ADC_C_Valid and ADC_C_Channel stay stable; accept on cycle 6 -> exactly one command issued.
- FR=1, MASK=0x01 -> back-to-back sequences on ch0. Clear EN -> the sequence in flight finishes, then BUSY=0 with no further commands.
- With ADC_MAX10_TRIGGER_EN, TE=1: ADC_Trigger 0->1 -> sequence starts within 4 cycles. Second edge while BUSY -> ignored.
- Assert RESET while in RESP -> next cycle BUSY=0 and ADC_C_Valid=0; the later ADC_R_Valid leaves DATA unchanged.
